ping_capture: RTL and testbench

PING_CAPTURE -- requirements
Module: ping_capture

---
 rtl/ping_capture.sv | 132 +++++++++++++
 tb/tb_ping_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_capture.sv
// Pre/post-trigger capture buffer for an ADC sample stream. It keeps a rolling
// window of PRE samples, triggers on |sample - MID| > threshold, and freezes for readout.
module ping_capture #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 64,
    parameter int PRE    = 16,
    parameter int MID    = 512
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic                       sample_valid,
    input  logic [DATA_W-1:0]          threshold,
    input  logic                       arm,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     PRE_LAST  = CW'(PRE - 1);
    localparam logic [CW-1:0]     POST_LAST = CW'(DEPTH - PRE - 2);
    localparam logic [AW-1:0]     PRE_OFS   = AW'(PRE);
    localparam logic [DATA_W-1:0] MID_W     = DATA_W'(MID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_fill_cnt;
    logic [CW-1:0]      r_post_cnt;
    logic [AW-1:0]      r_trig_ptr;
    logic [AW-1:0]      r_start_ptr;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_valid;
    logic               r_busy;
    logic               r_done;

    logic [DATA_W-1:0]  w_mag;
    logic               w_capturing;
    logic               w_we;
    logic               w_trig;
    logic               w_arm_ok;
    logic               w_post_last;
    logic               w_nxt_busy;

    always_comb begin
        w_mag       = (sample_in >= MID_W) ? (sample_in - MID_W) : (MID_W - sample_in);
        w_capturing = (r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST);
        w_we        = sample_valid && w_capturing;
        w_trig      = (r_state == S_ARMED) && sample_valid && (w_mag > threshold);
        w_arm_ok    = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_post_last = (r_state == S_POST) && sample_valid && (r_post_cnt == POST_LAST);

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_state_nxt = S_FILL;
            S_FILL:  if (sample_valid && (r_fill_cnt == PRE_LAST)) w_state_nxt = S_ARMED;
            S_ARMED: if (w_trig) w_state_nxt = S_POST;
            S_POST:  if (w_post_last) w_state_nxt = S_DONE;
            S_DONE:  if (arm) w_state_nxt = S_FILL;
            default: w_state_nxt = S_IDLE;
        endcase

        w_nxt_busy = (w_state_nxt == S_FILL) || (w_state_nxt == S_ARMED) ||
                     (w_state_nxt == S_POST);
    end

    // busy/done are flopped from the next-state decode so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_post_cnt  <= '0;
            r_trig_ptr  <= '0;
            r_start_ptr <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_nxt_busy;
            r_done  <= (w_state_nxt == S_DONE);

            if (w_arm_ok) begin
                r_wr_ptr   <= '0;
                r_fill_cnt <= '0;
                r_post_cnt <= '0;
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_state == S_FILL) r_fill_cnt <= r_fill_cnt + 1'b1;
                if (r_state == S_POST) r_post_cnt <= r_post_cnt + 1'b1;
            end

            if (w_trig) r_trig_ptr <= r_wr_ptr;
            if (w_post_last) r_start_ptr <= r_trig_ptr - PRE_OFS;

            // A coincident arm wins over the read.
            if ((r_state == S_DONE) && rd_en && !arm) begin
                r_rd_data  <= r_mem[r_start_ptr + rd_addr];
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_we) r_mem[r_wr_ptr] <= sample_in;
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_ping_capture.sv
// Directed bench for ping_capture: trigger threshold edges, pointer wrap,
// mid-capture reset and streaming readout, with hand-computed expectations.
module tb_ping_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic [9:0] threshold = 10'd50;
    logic       arm = 1'b0;
    logic       rd_en = 1'b0;
    logic [5:0] rd_addr = '0;
    logic [9:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ping_capture #(.DATA_W(10), .DEPTH(64), .PRE(16), .MID(512)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .threshold(threshold), .arm(arm), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read1(input logic [5:0] a, output logic [9:0] d, output logic v);
        rd_addr = a;
        rd_en   = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    // Pre: 500+i, trigger: 600, post: 10*j.
    function automatic logic [9:0] std_word(input int i);
        if (i < 16) return 10'(500 + i);
        if (i == 16) return 10'd600;
        return 10'(10 * (i - 17));
    endfunction

    task automatic test_reset;
        reset = 1'b1; arm = 1'b1; sample_valid = 1'b1; rd_en = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b0; sample_valid = 1'b0; rd_en = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 10'd0) begin n_err++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    endtask

    task automatic test_basic;
        logic [9:0] d;
        logic v;
        threshold = 10'd50;
        do_arm();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_arm got %b want 1", busy); end
        read1(6'd0, d, v);
        n_cmp++; if (v !== 1'b0) begin n_err++; $display("FAIL basic_read_while_busy got %b want 0", v); end
        for (int i = 0; i < 16; i++) send(10'd512);
        send(10'd600);
        for (int j = 0; j < 46; j++) send(10'(j));
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL basic_post46 got done=%b busy=%b want done=0 busy=1", done, busy);
        end
        send(10'd46);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_post47 got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        read1(6'd16, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 10'd600) begin n_err++; $display("FAIL basic_rd16 got %0d/%b want 600/1", d, v); end
        read1(6'd0, d, v);
        n_cmp++; if (d !== 10'd512) begin n_err++; $display("FAIL basic_rd0 got %0d want 512", d); end
        read1(6'd17, d, v);
        n_cmp++; if (d !== 10'd0) begin n_err++; $display("FAIL basic_rd17 got %0d want 0", d); end
        read1(6'd63, d, v);
        n_cmp++; if (d !== 10'd46) begin n_err++; $display("FAIL basic_rd63 got %0d want 46", d); end
    endtask

    task automatic test_threshold;
        logic [9:0] d;
        logic v;
        logic [9:0] tv [2];
        threshold = 10'd50;
        do_arm();
        for (int i = 0; i < 16; i++) send(10'd512);
        send(10'd562);
        send(10'd462);
        send(10'd512);
        send(10'd461);
        for (int j = 0; j < 46; j++) send(10'd7);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL thr_early_done got %b want 0", done); end
        send(10'd7);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL thr_done got %b want 1", done); end
        read1(6'd16, d, v);
        n_cmp++; if (d !== 10'd461) begin n_err++; $display("FAIL thr_rd16 got %0d want 461", d); end
        read1(6'd14, d, v);
        n_cmp++; if (d !== 10'd462) begin n_err++; $display("FAIL thr_rd14 got %0d want 462", d); end
        read1(6'd13, d, v);
        n_cmp++; if (d !== 10'd562) begin n_err++; $display("FAIL thr_rd13 got %0d want 562", d); end

        tv[0] = 10'd0;
        tv[1] = 10'd1023;
        for (int k = 0; k < 2; k++) begin
            do_arm();
            for (int i = 0; i < 16; i++) send(10'd512);
            send(tv[k]);
            for (int j = 0; j < 46; j++) send(10'd512);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL thr_ext%0d_early got %b want 0", k, done); end
            send(10'd512);
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL thr_ext%0d_done got %b want 1", k, done); end
            read1(6'd16, d, v);
            n_cmp++; if (d !== tv[k]) begin n_err++; $display("FAIL thr_ext%0d_rd16 got %0d want %0d", k, d, tv[k]); end
        end
    endtask

    task automatic test_wrap;
        logic [9:0] d;
        logic v;
        threshold = 10'd1000;
        do_arm();
        for (int i = 0; i < 200; i++) send(10'(i));
        threshold = 10'd50;
        send(10'd1023);
        for (int j = 0; j < 47; j++) send(10'd5);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done got %b want 1", done); end
        for (int i = 0; i < 16; i++) begin
            read1(6'(i), d, v);
            n_cmp++; if (d !== 10'(184 + i) || v !== 1'b1) begin
                n_err++; $display("FAIL wrap_rd%0d got %0d/%b want %0d/1", i, d, v, 184 + i);
            end
        end
        read1(6'd16, d, v);
        n_cmp++; if (d !== 10'd1023) begin n_err++; $display("FAIL wrap_rd16 got %0d want 1023", d); end
    endtask

    task automatic test_fill_trigger;
        logic [9:0] d;
        logic v;
        threshold = 10'd50;
        do_arm();
        for (int i = 0; i < 16; i++) send((i == 4) ? 10'd1000 : 10'd512);
        send(10'd512);
        send(10'd600);
        for (int j = 0; j < 46; j++) send(10'd512);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL fill_early_done got %b want 0", done); end
        send(10'd512);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fill_done got %b want 1", done); end
        read1(6'd3, d, v);
        n_cmp++; if (d !== 10'd1000) begin n_err++; $display("FAIL fill_rd3 got %0d want 1000", d); end
        read1(6'd16, d, v);
        n_cmp++; if (d !== 10'd600) begin n_err++; $display("FAIL fill_rd16 got %0d want 600", d); end
    endtask

    task automatic test_reset_mid_post;
        threshold = 10'd50;
        do_arm();
        for (int i = 0; i < 16; i++) send(10'(500 + i));
        send(10'd600);
        for (int j = 0; j < 9; j++) send(10'd1);
        sample_in = 10'd2; sample_valid = 1'b1; reset = 1'b1;
        tick();
        sample_valid = 1'b0; reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst got busy=%b done=%b want 0/0", busy, done);
        end
        for (int j = 0; j < 40; j++) send(10'd3);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst_idle got busy=%b done=%b want 0/0", busy, done);
        end
        do_arm();
        for (int i = 0; i < 64; i++) send(std_word(i));
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_recapture got done=%b busy=%b want 1/0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            tick();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== std_word(i)) begin
                n_err++; $display("FAIL b2b_rd%0d got %0d/%b want %0d/1", i, rd_data, rd_valid, std_word(i));
            end
        end
        rd_en = 1'b0;
        tick();
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 10'd460) begin
            n_err++; $display("FAIL b2b_idle got %0d/%b want 460/0", rd_data, rd_valid);
        end
        rd_en = 1'b1; arm = 1'b1; rd_addr = 6'd5;
        tick();
        rd_en = 1'b0; arm = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL arm_vs_read got valid=%b busy=%b done=%b want 0/1/0", rd_valid, busy, done);
        end
        n_cmp++; if (rd_data !== 10'd460) begin n_err++; $display("FAIL arm_vs_read_hold got %0d want 460", rd_data); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_basic();
        test_threshold();
        test_wrap();
        test_fill_trigger();
        test_reset_mid_post();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
